rf_wb_arbiter: RTL and testbench

Write-port arbiter and load scoreboard for the core's 32x32 register file. Two writeback sources share the file's single write port: the ALU/execute path (port 0) and the cache load-return path (port 1). It drives `reg_wr`/`waddr`/`wdata` from registers and tracks destination registers of outstanding loads, so issue logic can stall on read-after-write hazards.

---
 rtl/rf_wb_arbiter.sv | 107 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin write-port arbiter for the 32x32 register file
// plus a load scoreboard. Port 0 is the ALU writeback path and port 1 is the
// cache load-return path. The write port outputs are registered. The
// scoreboard marks destinations of outstanding loads so that issue logic can
// stall on read-after-write hazards.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_waddr,
  input  logic [DATA_W-1:0] s0_wdata,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_waddr,
  input  logic [DATA_W-1:0] s1_wdata,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              reg_wr,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam int NREG = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_req_t;

  wb_req_t          req0, req1, sel;
  logic             gnt0, gnt1, any_gnt;
  logic             last;          // 1: s1 won the last grant, so s0 is favoured next
  logic [NREG-1:0]  pending, pending_nxt;

  assign req0 = '{waddr: s0_waddr, wdata: s0_wdata};
  assign req1 = '{waddr: s1_waddr, wdata: s1_wdata};

  // Round-robin grant. No grant is issued while reset is held, so a source
  // never sees a handshake that the reset would discard.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (!reset) begin
      gnt0 = s0_valid && (!s1_valid || last);
      gnt1 = s1_valid && (!s0_valid || !last);
    end
    any_gnt = gnt0 | gnt1;
    sel     = gnt1 ? req1 : req0;
  end

  assign s0_ready = gnt0;
  assign s1_ready = gnt1;

  // The round-robin pointer moves only when a transfer happens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last <= 1'b1;
    else if (any_gnt) last <= gnt1;
  end

  // Registered write port. Writes to x0 are accepted but suppressed here.
  // waddr and wdata hold their values between grants.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_wr <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
    end else if (any_gnt) begin
      reg_wr <= (sel.waddr != '0);
      waddr  <= sel.waddr;
      wdata  <= sel.wdata;
    end else begin
      reg_wr <= 1'b0;
    end
  end

  // Scoreboard next state. The clear is applied first so that a new load to
  // the same register in the same cycle leaves the bit set.
  always_comb begin
    pending_nxt = pending;
    if (gnt1)
      pending_nxt[s1_waddr] = 1'b0;
    if (sb_set && (sb_addr != '0))
      pending_nxt[sb_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  // Hazard lookups come from registered state only.
  always_comb begin
    hazard1 = (chk_addr1 != '0) && pending[chk_addr1];
    hazard2 = (chk_addr2 != '0) && pending[chk_addr2];
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter. It runs directed scenarios and then
// randomized traffic. A behavioural model tracks who was granted last, the
// set of registers with outstanding loads, and the expected write-port
// contents.
module tb_rf_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              s0_valid = 1'b0, s1_valid = 1'b0;
  logic              s0_ready, s1_ready;
  logic [ADDR_W-1:0] s0_waddr = '0, s1_waddr = '0;
  logic [DATA_W-1:0] s0_wdata = '0, s1_wdata = '0;
  logic              sb_set = 1'b0;
  logic [ADDR_W-1:0] sb_addr = '0, chk_addr1 = '0, chk_addr2 = '0;
  logic              hazard1, hazard2;
  logic              reg_wr;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_last_src;     // source that won the most recent grant
  bit          m_pend[32];     // registers with a load outstanding
  bit          m_wr;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_g0, m_g1;     // grants that happened at the last edge

  rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_waddr(s0_waddr), .s0_wdata(s0_wdata),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_waddr(s1_waddr), .s1_wdata(s1_wdata),
    .sb_set(sb_set), .sb_addr(sb_addr), .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hazard1(hazard1), .hazard2(hazard2),
    .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_last_src = 1;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_wr = 1'b0; m_waddr = '0; m_wdata = '0;
    m_g0 = 1'b0; m_g1 = 1'b0;
  endfunction

  // A lone requester wins. Under contention, the source that did not win
  // last time wins. Nothing is granted while reset is held.
  function automatic void model_grant(output bit g0, output bit g1);
    g0 = 1'b0; g1 = 1'b0;
    if (reset) return;
    if (s0_valid && s1_valid) begin
      if (m_last_src == 0) g1 = 1'b1; else g0 = 1'b1;
    end else begin
      g0 = s0_valid;
      g1 = s1_valid;
    end
  endfunction

  // Advance one clock edge and apply the spec rules to the model.
  task automatic tick();
    bit g0, g1;
    model_grant(g0, g1);
    @(posedge clk);
    m_g0 = g0; m_g1 = g1;
    if (g0 || g1) begin
      m_waddr    = g1 ? s1_waddr : s0_waddr;
      m_wdata    = g1 ? s1_wdata : s0_wdata;
      m_wr       = (m_waddr != 0);
      m_last_src = g1 ? 1 : 0;
    end else begin
      m_wr = 1'b0;
    end
    if (g1) m_pend[s1_waddr] = 1'b0;
    if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s0_valid = 0; s1_valid = 0; sb_set = 0;
    #1 model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (reg_wr !== 1'b0 || waddr !== '0 || wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%0b addr=%0d data=%h, want 0/0/0", reg_wr, waddr, wdata);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %0b%0b, want 00", s0_ready, s1_ready);
    end
    for (int i = 0; i < 32; i++) begin
      chk_addr1 = 5'(i); chk_addr2 = 5'(31 - i);
      #1;
      checks++;
      if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hazard[%0d]: got %0b%0b, want 00", i, hazard1, hazard2);
      end
    end
  endtask

  task automatic test_s0_single();
    s0_valid = 1; s0_waddr = 5; s0_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
      errors++;
      $display("FAIL s0_single_ready: got %0b%0b, want 10", s0_ready, s1_ready);
    end
    tick();
    s0_valid = 0;
    checks++;
    if (reg_wr !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL s0_single_write: got wr=%0b addr=%0d data=%h, want 1/5/deadbeef", reg_wr, waddr, wdata);
    end
    tick();
    checks++;
    if (reg_wr !== 1'b0 || waddr !== 5'd5) begin
      errors++;
      $display("FAIL s0_single_idle: got wr=%0b addr=%0d, want 0/5", reg_wr, waddr);
    end
  endtask

  task automatic test_alternate();
    logic [4:0] exp_seq [4];
    exp_seq = '{5'd3, 5'd7, 5'd3, 5'd7};
    do_reset();
    s0_valid = 1; s0_waddr = 3; s0_wdata = 32'h3333_0000;
    s1_valid = 1; s1_waddr = 7; s1_wdata = 32'h7777_0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (s0_ready !== (i % 2 == 0) || s1_ready !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL alternate_ready[%0d]: got %0b%0b, want s0=%0b", i, s0_ready, s1_ready, i % 2 == 0);
      end
      tick();
      s0_wdata = s0_wdata + 1;
      s1_wdata = s1_wdata + 1;
      checks++;
      if (reg_wr !== 1'b1 || waddr !== exp_seq[i] || wdata !== m_wdata) begin
        errors++;
        $display("FAIL alternate_write[%0d]: got wr=%0b addr=%0d data=%h, want 1/%0d/%h", i, reg_wr, waddr, wdata, exp_seq[i], m_wdata);
      end
    end
    s0_valid = 0; s1_valid = 0;
    tick();
  endtask

  task automatic test_scoreboard();
    sb_set = 1; sb_addr = 9; chk_addr1 = 9;
    #1;
    checks++;
    if (hazard1 !== 1'b0) begin
      errors++;
      $display("FAIL sb_before_set: got %0b, want 0", hazard1);
    end
    tick();
    sb_set = 0;
    #1;
    checks++;
    if (hazard1 !== 1'b1) begin
      errors++;
      $display("FAIL sb_after_set: got %0b, want 1", hazard1);
    end
    s1_valid = 1; s1_waddr = 9; s1_wdata = 32'h0900_0009;
    #1;
    checks++;
    if (s1_ready !== 1'b1 || hazard1 !== 1'b1) begin
      errors++;
      $display("FAIL sb_load_grant: got ready=%0b hazard=%0b, want 1/1", s1_ready, hazard1);
    end
    tick();
    s1_valid = 0;
    checks++;
    if (hazard1 !== 1'b0 || reg_wr !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h0900_0009) begin
      errors++;
      $display("FAIL sb_clear: got hazard=%0b wr=%0b addr=%0d data=%h, want 0/1/9/09000009", hazard1, reg_wr, waddr, wdata);
    end
  endtask

  task automatic test_set_clear_same();
    sb_set = 1; sb_addr = 12; chk_addr2 = 12;
    tick();
    sb_set = 0;
    #1;
    checks++;
    if (hazard2 !== 1'b1) begin
      errors++;
      $display("FAIL same_pre: got %0b, want 1", hazard2);
    end
    sb_set = 1; sb_addr = 12;
    s1_valid = 1; s1_waddr = 12; s1_wdata = 32'h1212_1212;
    tick();
    sb_set = 0; s1_valid = 0;
    checks++;
    if (hazard2 !== 1'b1 || reg_wr !== 1'b1 || waddr !== 5'd12) begin
      errors++;
      $display("FAIL same_set_wins: got hazard=%0b wr=%0b addr=%0d, want 1/1/12", hazard2, reg_wr, waddr);
    end
    sb_set = 1; sb_addr = 0; chk_addr1 = 0;
    tick();
    sb_set = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (hazard1 !== 1'b0) begin
        errors++;
        $display("FAIL sb_x0[%0d]: got %0b, want 0", i, hazard1);
      end
      tick();
    end
  endtask

  task automatic test_x0_and_reset();
    s1_valid = 1; s1_waddr = 0; s1_wdata = 32'hBAD0_0000;
    #1;
    checks++;
    if (s1_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready: got %0b, want 1", s1_ready);
    end
    tick();
    s1_valid = 0;
    checks++;
    if (reg_wr !== 1'b0) begin
      errors++;
      $display("FAIL x0_write: got wr=%0b, want 0", reg_wr);
    end
    // Mid-stream reset with both sources valid and register 12 pending.
    s0_valid = 1; s0_waddr = 4; s0_wdata = 32'h4;
    s1_valid = 1; s1_waddr = 6; s1_wdata = 32'h6;
    chk_addr2 = 12;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (reg_wr !== 1'b0 || waddr !== '0 || wdata !== '0 || hazard2 !== 1'b0 ||
        s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got wr=%0b addr=%0d data=%h hz=%0b rdy=%0b%0b, want all 0",
               reg_wr, waddr, wdata, hazard2, s0_ready, s1_ready);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_contention: got %0b%0b, want 10", s0_ready, s1_ready);
    end
    tick();
    checks++;
    if (reg_wr !== 1'b1 || waddr !== 5'd4) begin
      errors++;
      $display("FAIL post_reset_write: got wr=%0b addr=%0d, want 1/4", reg_wr, waddr);
    end
    s0_valid = 0; s1_valid = 0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!s0_valid || m_g0) begin
        s0_valid = ($urandom_range(0, 3) != 0);
        s0_waddr = 5'($urandom_range(0, 31));
        s0_wdata = $urandom;
      end
      if (!s1_valid || m_g1) begin
        s1_valid = ($urandom_range(0, 2) != 0);
        s1_waddr = 5'($urandom_range(0, 15));
        s1_wdata = $urandom;
      end
      sb_set    = ($urandom_range(0, 2) == 0);
      sb_addr   = 5'($urandom_range(0, 15));
      chk_addr1 = 5'($urandom_range(0, 15));
      chk_addr2 = 5'($urandom_range(0, 31));
      #1;
      begin
        bit g0, g1;
        model_grant(g0, g1);
        checks++;
        if (s0_ready !== g0 || s1_ready !== g1 ||
            hazard1 !== m_pend[chk_addr1] || hazard2 !== m_pend[chk_addr2]) begin
          errors++;
          $display("FAIL rand_comb[%0d]: got rdy=%0b%0b hz=%0b%0b, want rdy=%0b%0b hz=%0b%0b",
                   c, s0_ready, s1_ready, hazard1, hazard2, g0, g1, m_pend[chk_addr1], m_pend[chk_addr2]);
        end
      end
      tick();
      checks++;
      if (reg_wr !== m_wr || waddr !== m_waddr || wdata !== m_wdata) begin
        errors++;
        $display("FAIL rand_write[%0d]: got wr=%0b addr=%0d data=%h, want %0b/%0d/%h",
                 c, reg_wr, waddr, wdata, m_wr, m_waddr, m_wdata);
      end
    end
    s0_valid = 0; s1_valid = 0; sb_set = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_s0_single();
    test_alternate();
    test_scoreboard();
    test_set_clear_same();
    test_x0_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
